// File: rtl/ray_issue_if.sv
// Four-lane ray write bus: origin_1/origin_2/dir_1/dir_2, each lane with a write
// enable and a full flag. Signed Q16.16 vectors indexed [0]=x, [1]=y, [2]=z.
interface ray_issue_if;
  logic        [3:0]  in_wr_en;
  logic        [3:0]  in_full;
  logic signed [31:0] origin_1 [2:0];
  logic signed [31:0] origin_2 [2:0];
  logic signed [31:0] dir_1    [2:0];
  logic signed [31:0] dir_2    [2:0];

  modport master (
    output in_wr_en, origin_1, origin_2, dir_1, dir_2,
    input  in_full
  );

  modport slave (
    input  in_wr_en, origin_1, origin_2, dir_1, dir_2,
    output in_full
  );
endinterface

// File: rtl/ray_issue.sv
// Primary camera ray issuer: scans IMG_W x IMG_H pixels, two adjacent pixels per beat.
// Optional stall counter output enabled by defining RAY_ISSUE_STALL_CNT_EN.
module ray_issue #(
  parameter int Q_BITS = 16,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic signed [31:0] cam_origin [2:0],
  input  logic signed [31:0] dir_x0,
  input  logic signed [31:0] dir_y0,
  input  logic signed [31:0] dir_step,
  input  logic signed [31:0] dir_z,
  ray_issue_if.master        bus,
  output logic               busy,
  output logic               done
`ifdef RAY_ISSUE_STALL_CNT_EN
  ,
  output logic        [31:0] stall_cnt
`endif
);

  localparam int DATA_W = 32;
  localparam int CW     = $clog2(IMG_W + 1);
  localparam int RW     = $clog2(IMG_H + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 2);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  if (IMG_W < 2 || (IMG_W % 2) != 0 || IMG_H < 1 || Q_BITS < 0 || Q_BITS >= DATA_W) begin : g_bad_cfg
    $error("ray_issue: IMG_W must be even and >= 2, IMG_H >= 1, 0 <= Q_BITS < 32");
  end

  function automatic logic signed [DATA_W-1:0] wrap_add(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return a + b;
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                    state;
  logic        [CW-1:0]      col;
  logic        [RW-1:0]      row;
  logic signed [DATA_W-1:0]  acc_x;
  logic signed [DATA_W-1:0]  acc_y;
  logic signed [DATA_W-1:0]  org [2:0];
  logic signed [DATA_W-1:0]  x0_l;
  logic signed [DATA_W-1:0]  step_l;
  logic signed [DATA_W-1:0]  z_l;
  logic signed [DATA_W-1:0]  step2;
  logic                      beat;

  // Doubling the step drops its MSB; wrap-around is the intended arithmetic.
  assign step2 = {step_l[DATA_W-2:0], 1'b0};

  // One full flag blocks every lane so the four FIFOs never drift apart.
  assign beat          = (state == RUN) && (bus.in_full == 4'b0000);
  assign bus.in_wr_en  = {4{beat}};

  assign bus.origin_1  = org;
  assign bus.origin_2  = org;
  assign bus.dir_1[0]  = acc_x;
  assign bus.dir_1[1]  = acc_y;
  assign bus.dir_1[2]  = z_l;
  assign bus.dir_2[0]  = wrap_add(acc_x, step_l);
  assign bus.dir_2[1]  = acc_y;
  assign bus.dir_2[2]  = z_l;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      col    <= '0;
      row    <= '0;
      acc_x  <= '0;
      acc_y  <= '0;
      org    <= '{default: '0};
      x0_l   <= '0;
      step_l <= '0;
      z_l    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            org    <= cam_origin;
            x0_l   <= dir_x0;
            step_l <= dir_step;
            z_l    <= dir_z;
            acc_x  <= dir_x0;
            acc_y  <= dir_y0;
            col    <= '0;
            row    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (beat) begin
            if (col == COL_LAST) begin
              col   <= '0;
              acc_x <= x0_l;
              row   <= row + RW'(1);
              acc_y <= wrap_add(acc_y, step_l);
              if (row == ROW_LAST) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end
            end else begin
              col   <= col + CW'(2);
              acc_x <= wrap_add(acc_x, step2);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef RAY_ISSUE_STALL_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (state == IDLE && start) begin
      stall_cnt <= '0;
    end else if (state == RUN && bus.in_full != 4'b0000 && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ray_issue.sv
// Scoreboard bench for ray_issue on a 4x2 grid: beats are predicted from the
// pixel coordinates and matched against the bus whenever the write enables fire.
module tb_ray_issue;
  localparam int W = 4;
  localparam int H = 2;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic signed [31:0] cam_origin [2:0];
  logic signed [31:0] dir_x0, dir_y0, dir_step, dir_z;
  logic               busy, done;
`ifdef RAY_ISSUE_STALL_CNT_EN
  logic        [31:0] stall_cnt;
`endif

  int total  = 0;
  int passed = 0;
  logic [383:0] sb [$];

  ray_issue_if bus ();

  ray_issue #(.Q_BITS(16), .IMG_W(W), .IMG_H(H)) dut (
    .clock(clock), .reset(reset), .start(start), .cam_origin(cam_origin),
    .dir_x0(dir_x0), .dir_y0(dir_y0), .dir_step(dir_step), .dir_z(dir_z),
    .bus(bus), .busy(busy), .done(done)
`ifdef RAY_ISSUE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  function automatic logic [383:0] obs();
    return {bus.origin_1[0], bus.origin_1[1], bus.origin_1[2],
            bus.origin_2[0], bus.origin_2[1], bus.origin_2[2],
            bus.dir_1[0], bus.dir_1[1], bus.dir_1[2],
            bus.dir_2[0], bus.dir_2[1], bus.dir_2[2]};
  endfunction

  task automatic set_cfg(input logic [31:0] x0);
    cam_origin[0] = 32'h0;
    cam_origin[1] = 32'h0;
    cam_origin[2] = 32'hFFFB0000;
    dir_x0   = x0;
    dir_y0   = 32'hFFFF0000;
    dir_step = 32'h00010000;
    dir_z    = 32'h00010000;
  endtask

  // Expected beats for the currently applied configuration, pixel by pixel.
  task automatic push_frame();
    logic [31:0] x1, x2, y;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c += 2) begin
        x1 = dir_x0 + 32'(c) * dir_step;
        x2 = dir_x0 + 32'(c + 1) * dir_step;
        y  = dir_y0 + 32'(r) * dir_step;
        sb.push_back({cam_origin[0], cam_origin[1], cam_origin[2],
                      cam_origin[0], cam_origin[1], cam_origin[2],
                      x1, y, dir_z, x2, y, dir_z});
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; bus.in_full = 4'h0;
    set_cfg(32'hFFFE0000);
    repeat (2) @(negedge clock);
    #1;
    total++; if (bus.in_wr_en !== 4'h0) $display("FAIL reset_wr_en got %h want 0", bus.in_wr_en); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (obs() !== 384'h0) $display("FAIL reset_data got %h want 0", obs()); else passed++;
`ifdef RAY_ISSUE_STALL_CNT_EN
    total++; if (stall_cnt !== 32'h0) $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); else passed++;
`endif
    @(negedge clock); reset = 1'b0;
  endtask

  task automatic test_basic();
    int beats = 0, dones = 0, first = -1, last = -1, donec = -1;
    logic [383:0] e;
    sb.delete(); set_cfg(32'hFFFE0000); push_frame();
    for (int c = 0; c < 12; c++) begin
      @(negedge clock); start = (c == 0); #1;
      if (bus.in_wr_en === 4'hF) begin
        total++;
        if (sb.size() == 0) $display("FAIL basic_extra_beat at cycle %0d", c);
        else begin
          e = sb.pop_front();
          if (obs() !== e) $display("FAIL basic_beat%0d got %h want %h", beats, obs(), e); else passed++;
        end
        if (first < 0) first = c;
        last = c; beats++;
      end else begin
        total++; if (bus.in_wr_en !== 4'h0) $display("FAIL basic_lanes got %h want 0 or f", bus.in_wr_en); else passed++;
      end
      if (done === 1'b1) begin dones++; donec = c; end
    end
    total++; if (first != 1) $display("FAIL basic_latency got %0d want 1", first); else passed++;
    total++; if (beats != 4) $display("FAIL basic_beats got %0d want 4", beats); else passed++;
    total++; if (dones != 1) $display("FAIL basic_dones got %0d want 1", dones); else passed++;
    total++; if (donec != last + 1) $display("FAIL basic_done_cycle got %0d want %0d", donec, last + 1); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL basic_busy_end got %b want 0", busy); else passed++;
  endtask

  task automatic test_backpressure();
    int beats = 0, dones = 0, stalls = 0;
    logic [383:0] e;
    sb.delete(); set_cfg(32'hFFFE0000); push_frame();
    for (int c = 0; c < 16; c++) begin
      @(negedge clock);
      start = (c == 0);
      case (c)
        2: bus.in_full = 4'b0100;
        3: bus.in_full = 4'b0110;
        4: bus.in_full = 4'b1100;
        5: bus.in_full = 4'b0101;
        6: bus.in_full = 4'b0100;
        default: bus.in_full = 4'b0000;
      endcase
      #1;
      if (c >= 2 && c <= 6) begin
        stalls++;
        total++; if (bus.in_wr_en !== 4'h0) $display("FAIL bp_stall_wr_en cycle %0d got %h want 0", c, bus.in_wr_en); else passed++;
        total++; if (sb.size() == 0 || obs() !== sb[0]) $display("FAIL bp_hold cycle %0d got %h", c, obs()); else passed++;
      end
      if (bus.in_wr_en === 4'hF) begin
        total++;
        if (sb.size() == 0) $display("FAIL bp_extra_beat at cycle %0d", c);
        else begin
          e = sb.pop_front();
          if (obs() !== e) $display("FAIL bp_beat%0d got %h want %h", beats, obs(), e); else passed++;
        end
        if (beats == 1) begin
          total++; if (c != 7) $display("FAIL bp_resume_cycle got %0d want 7", c); else passed++;
        end
        beats++;
      end
      if (done === 1'b1) dones++;
    end
    total++; if (beats != 4) $display("FAIL bp_beats got %0d want 4", beats); else passed++;
    total++; if (dones != 1) $display("FAIL bp_dones got %0d want 1", dones); else passed++;
`ifdef RAY_ISSUE_STALL_CNT_EN
    total++; if (stall_cnt !== 32'(stalls)) $display("FAIL bp_stall_cnt got %0d want %0d", stall_cnt, stalls); else passed++;
`endif
  endtask

`ifdef RAY_ISSUE_STALL_CNT_EN
  task automatic test_stall_cnt();
    int beats = 0;
    logic [383:0] e;
    sb.delete(); set_cfg(32'hFFFE0000); push_frame();
    for (int c = 0; c < 8; c++) begin
      @(negedge clock); start = (c == 0); #1;
      if (c == 1) begin
        total++; if (stall_cnt !== 32'h0) $display("FAIL stall_clear got %0d want 0", stall_cnt); else passed++;
      end
      if (bus.in_wr_en === 4'hF) begin
        total++;
        if (sb.size() == 0) $display("FAIL sc_extra_beat at cycle %0d", c);
        else begin
          e = sb.pop_front();
          if (obs() !== e) $display("FAIL sc_beat%0d got %h want %h", beats, obs(), e); else passed++;
        end
        beats++;
      end
    end
    total++; if (beats != 4) $display("FAIL sc_beats got %0d want 4", beats); else passed++;
    total++; if (stall_cnt !== 32'h0) $display("FAIL sc_no_stall got %0d want 0", stall_cnt); else passed++;
  endtask
`endif

  task automatic test_start_busy();
    int beats = 0, dones = 0, last = -1, donec = -1;
    logic [383:0] e;
    sb.delete(); set_cfg(32'hFFFE0000); push_frame();
    for (int c = 0; c < 14; c++) begin
      @(negedge clock);
      start = (c == 0 || c == 2 || c == 8);
      if (c == 2) dir_x0 = 32'h00050000;
      case (c)
        3: bus.in_full = 4'b0001;
        4: bus.in_full = 4'b0010;
        5: bus.in_full = 4'b1000;
        default: bus.in_full = 4'b0000;
      endcase
      #1;
      if (c >= 3 && c <= 5) begin
        total++; if (bus.in_wr_en !== 4'h0) $display("FAIL sb_single_flag cycle %0d got %h want 0", c, bus.in_wr_en); else passed++;
      end
      if (bus.in_wr_en === 4'hF) begin
        total++;
        if (sb.size() == 0) $display("FAIL busy_extra_beat at cycle %0d", c);
        else begin
          e = sb.pop_front();
          if (obs() !== e) $display("FAIL busy_beat%0d got %h want %h", beats, obs(), e); else passed++;
        end
        beats++; last = c;
      end
      if (done === 1'b1) begin dones++; donec = c; end
    end
    total++; if (beats != 4) $display("FAIL busy_beats got %0d want 4", beats); else passed++;
    total++; if (dones != 1) $display("FAIL busy_dones got %0d want 1", dones); else passed++;
    total++; if (donec != 8) $display("FAIL busy_done_cycle got %0d want 8 (last beat %0d)", donec, last); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL busy_after_done_start got %b want 0", busy); else passed++;
  endtask

  task automatic test_reset_mid();
    int beats = 0, dones = 0;
    logic [383:0] e;
    sb.delete(); set_cfg(32'hFFFE0000); push_frame();
    for (int c = 0; c < 9; c++) begin
      @(negedge clock); start = (c == 0); reset = (c == 3); #1;
      if (c == 3) begin
        total++; if (bus.in_wr_en !== 4'h0) $display("FAIL rm_wr_en got %h want 0", bus.in_wr_en); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rm_busy got %b want 0", busy); else passed++;
      end
      if (bus.in_wr_en === 4'hF) begin
        total++;
        if (sb.size() == 0) $display("FAIL rm_extra_beat at cycle %0d", c);
        else begin
          e = sb.pop_front();
          if (obs() !== e) $display("FAIL rm_beat%0d got %h want %h", beats, obs(), e); else passed++;
        end
        beats++;
      end
      if (done === 1'b1) dones++;
    end
    total++; if (beats != 2) $display("FAIL rm_partial_beats got %0d want 2", beats); else passed++;
    total++; if (dones != 0) $display("FAIL rm_done_pulse got %0d want 0", dones); else passed++;
    beats = 0; dones = 0;
    sb.delete(); push_frame();
    for (int c = 0; c < 8; c++) begin
      @(negedge clock); start = (c == 0); #1;
      if (bus.in_wr_en === 4'hF) begin
        total++;
        if (sb.size() == 0) $display("FAIL rs_extra_beat at cycle %0d", c);
        else begin
          e = sb.pop_front();
          if (obs() !== e) $display("FAIL rs_beat%0d got %h want %h", beats, obs(), e); else passed++;
        end
        beats++;
      end
      if (done === 1'b1) dones++;
    end
    total++; if (beats != 4) $display("FAIL rs_beats got %0d want 4", beats); else passed++;
    total++; if (dones != 1) $display("FAIL rs_dones got %0d want 1", dones); else passed++;
  endtask

  task automatic test_wrap();
    int beats = 0;
    logic [383:0] e;
    sb.delete(); set_cfg(32'h7FFF0000); push_frame();
    for (int c = 0; c < 8; c++) begin
      @(negedge clock); start = (c == 0); #1;
      if (bus.in_wr_en === 4'hF) begin
        if (beats == 0) begin
          total++; if (bus.dir_2[0] !== 32'h80000000) $display("FAIL wrap_b0_dir2x got %h want 80000000", bus.dir_2[0]); else passed++;
        end
        if (beats == 1) begin
          total++; if (bus.dir_1[0] !== 32'h80010000) $display("FAIL wrap_b1_dir1x got %h want 80010000", bus.dir_1[0]); else passed++;
        end
        total++;
        if (sb.size() == 0) $display("FAIL wrap_extra_beat at cycle %0d", c);
        else begin
          e = sb.pop_front();
          if (obs() !== e) $display("FAIL wrap_beat%0d got %h want %h", beats, obs(), e); else passed++;
        end
        beats++;
      end
    end
    total++; if (beats != 4) $display("FAIL wrap_beats got %0d want 4", beats); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
`ifdef RAY_ISSUE_STALL_CNT_EN
    test_stall_cnt();
`endif
    test_start_busy();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
